// File: rtl/mem_lsu_pkg.sv
// Shared defines for the MIPS pipeline: ALU op codes and LSU FSM states.
// Load/store op codes sit alongside the existing ALU op codes.
package mem_lsu_pkg;

  localparam int ALU_OP_BUS_W = 8;

  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/mem_lsu_lane_align.sv
// Byte-lane steering for loads and stores (purely combinational).
// MEM_ALIGN_CHECK_EN adds a misaligned-access flag output.
module lsu_lane_align
  import mem_lsu_pkg::*;
#(
  parameter int ALUOP_W = 8
) (
  input  logic [ALUOP_W-1:0] op,
  input  logic [1:0]         addr_lo,
  input  logic [31:0]        rs2,
  input  logic [31:0]        rdata,
  output logic               is_load,
  output logic               is_store,
`ifdef MEM_ALIGN_CHECK_EN
  output logic               misaligned,
`endif
  output logic [3:0]         be,
  output logic [31:0]        wdata,
  output logic [31:0]        ldata
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  // pick the addressed byte and half-word out of the read word
  always_comb begin
    unique case (addr_lo)
      2'd0:    bsel = rdata[7:0];
      2'd1:    bsel = rdata[15:8];
      2'd2:    bsel = rdata[23:16];
      default: bsel = rdata[31:24];
    endcase
    hsel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // decode the op and steer lanes by access size
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    be       = 4'b0000;
    wdata    = 32'h0;
    ldata    = 32'h0;
    unique case (1'b1)
      op == ALUOP_W'(EXE_LB_OP): begin
        is_load = 1'b1;
        be      = 4'b1111;
        ldata   = {{24{bsel[7]}}, bsel};
      end
      op == ALUOP_W'(EXE_LBU_OP): begin
        is_load = 1'b1;
        be      = 4'b1111;
        ldata   = {24'h0, bsel};
      end
      op == ALUOP_W'(EXE_LH_OP): begin
        is_load = 1'b1;
        be      = 4'b1111;
        ldata   = {{16{hsel[15]}}, hsel};
      end
      op == ALUOP_W'(EXE_LHU_OP): begin
        is_load = 1'b1;
        be      = 4'b1111;
        ldata   = {16'h0, hsel};
      end
      op == ALUOP_W'(EXE_LW_OP): begin
        is_load = 1'b1;
        be      = 4'b1111;
        ldata   = rdata;
      end
      op == ALUOP_W'(EXE_SB_OP): begin
        is_store = 1'b1;
        be       = 4'b0001 << addr_lo;
        wdata    = {4{rs2[7:0]}};
      end
      op == ALUOP_W'(EXE_SH_OP): begin
        is_store = 1'b1;
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{rs2[15:0]}};
      end
      op == ALUOP_W'(EXE_SW_OP): begin
        is_store = 1'b1;
        be       = 4'b1111;
        wdata    = rs2;
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  // half-word ops need addr[0]=0, word ops need addr[1:0]=0
  always_comb begin
    misaligned = 1'b0;
    unique case (1'b1)
      op == ALUOP_W'(EXE_LH_OP),
      op == ALUOP_W'(EXE_LHU_OP),
      op == ALUOP_W'(EXE_SH_OP):
        misaligned = addr_lo[0];
      op == ALUOP_W'(EXE_LW_OP),
      op == ALUOP_W'(EXE_SW_OP):
        misaligned = |addr_lo;
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: bus handshake FSM, stall and writeback mux.
// MEM_ALIGN_CHECK_EN enables misalignment trapping and the addr_err_o port.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ALUOP_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ALUOP_W-1:0] alu_op_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        reg2_data_i,
  input  logic [4:0]         reg_waddr_i,
  input  logic               reg_we_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [4:0]         reg_waddr_o,
  output logic               reg_we_o,
  output logic [31:0]        reg_wdata_o,
  output logic               stall_from_mem,
  output logic               data_req,
  output logic               data_wr,
  output logic [3:0]         data_be,
  output logic [31:0]        data_addr,
  output logic [31:0]        data_wdata,
  input  logic               data_addr_ok,
  input  logic               data_data_ok,
  input  logic [31:0]        data_rdata
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic [1:0]         addr_err_o
`endif
);

  lsu_state_e  state;
  logic [31:0] rdata_q;
  logic        is_load;
  logic        is_store;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ldata;
  logic        mem_op;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  lsu_lane_align #(
    .ALUOP_W (ALUOP_W)
  ) u_align (
    .op         (alu_op_i),
    .addr_lo    (mem_addr_i[1:0]),
    .rs2        (reg2_data_i),
    .rdata      (rdata_q),
    .is_load    (is_load),
    .is_store   (is_store),
`ifdef MEM_ALIGN_CHECK_EN
    .misaligned (misaligned),
`endif
    .be         (be),
    .wdata      (wdata),
    .ldata      (ldata)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign mem_op = (is_load | is_store) & ~misaligned;
`else
  assign mem_op = is_load | is_store;
`endif

  // handshake FSM; rdata is latched on the cycle data_ok completes a load
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LSU_IDLE;
      rdata_q <= 32'h0;
    end else begin
      unique case (state)
        LSU_IDLE, LSU_REQ: begin
          if (mem_op) begin
            if (data_addr_ok && data_data_ok) begin
              state <= LSU_DONE;
              if (is_load) rdata_q <= data_rdata;
            end else if (data_addr_ok) begin
              state <= LSU_WAIT;
            end else begin
              state <= LSU_REQ;
            end
          end else begin
            state <= LSU_IDLE;
          end
        end
        LSU_WAIT: begin
          if (data_data_ok) begin
            state <= LSU_DONE;
            if (is_load) rdata_q <= data_rdata;
          end
        end
        LSU_DONE: state <= LSU_IDLE;
      endcase
    end
  end

  // bus drive, stall and writeback; load writes back only in DONE
  always_comb begin
    reg_waddr_o    = 5'd0;
    reg_we_o       = 1'b0;
    reg_wdata_o    = 32'h0;
    stall_from_mem = 1'b0;
    data_req       = 1'b0;
    data_wr        = 1'b0;
    data_be        = 4'b0000;
    data_addr      = 32'h0;
    data_wdata     = 32'h0;
    if (!rst) begin
      reg_waddr_o    = reg_waddr_i;
      stall_from_mem = mem_op && (state != LSU_DONE);
      data_req       = mem_op &&
                       (state == LSU_IDLE || state == LSU_REQ);
      if (mem_op) begin
        data_wr    = is_store;
        data_be    = be;
        data_addr  = {mem_addr_i[31:2], 2'b00};
        data_wdata = wdata;
      end
      if (is_load) begin
        reg_wdata_o = ldata;
        reg_we_o    = reg_we_i && mem_op && (state == LSU_DONE);
      end else if (is_store) begin
        reg_wdata_o = reg_wdata_i;
      end else begin
        reg_wdata_o = reg_wdata_i;
        reg_we_o    = reg_we_i;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // misaligned access flags for the exception unit, single cycle
  always_comb begin
    addr_err_o = 2'b00;
    if (!rst) addr_err_o = {is_store & misaligned, is_load & misaligned};
  end
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed table, reset corner, random.
// Expected values come from an arithmetic model of the lane rules.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  alu_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_data_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        stall_from_mem;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
`ifdef MEM_ALIGN_CHECK_EN
  logic [1:0]  addr_err_o;
`endif

  int checks = 0;
  int errors = 0;

  mem_lsu #(.ALUOP_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_op_i       (alu_op_i),
    .mem_addr_i     (mem_addr_i),
    .reg2_data_i    (reg2_data_i),
    .reg_waddr_i    (reg_waddr_i),
    .reg_we_i       (reg_we_i),
    .reg_wdata_i    (reg_wdata_i),
    .reg_waddr_o    (reg_waddr_o),
    .reg_we_o       (reg_we_o),
    .reg_wdata_o    (reg_wdata_o),
    .stall_from_mem (stall_from_mem),
    .data_req       (data_req),
    .data_wr        (data_wr),
    .data_be        (data_be),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_addr_ok   (data_addr_ok),
    .data_data_ok   (data_data_ok),
    .data_rdata     (data_rdata)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .addr_err_o     (addr_err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit m_is_store(input logic [7:0] op);
    return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
  endfunction

  function automatic bit m_is_mem(input logic [7:0] op);
    return m_is_store(op) || op == EXE_LB_OP || op == EXE_LBU_OP ||
           op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_LW_OP;
  endfunction

  function automatic logic [3:0] m_be(input logic [7:0] op,
                                      input logic [31:0] a);
    int b;
    b = int'(a % 4);
    if (op == EXE_SB_OP) return 4'(1 << b);
    if (op == EXE_SH_OP) return 4'(3 << (2 * (b / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op,
                                          input logic [31:0] d);
    if (op == EXE_SB_OP) return (d % 256) * 32'h0101_0101;
    if (op == EXE_SH_OP) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] r);
    logic [31:0] v;
    int b;
    b = int'(a % 4);
    v = r;
    if (op == EXE_LB_OP || op == EXE_LBU_OP) begin
      v = (r >> (8 * b)) % 256;
      if (op == EXE_LB_OP && v >= 128) v = v - 256;
    end else if (op == EXE_LH_OP || op == EXE_LHU_OP) begin
      v = (r >> (16 * (b / 2))) % 65536;
      if (op == EXE_LH_OP && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  task automatic idle_bus();
    alu_op_i     = EXE_NOP_OP;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    reg_we_i     = 1'b0;
  endtask

  // one access; addr_ok in cycle a, data_ok in cycle a+d, DONE in a+d+1
  task automatic run_acc(input string nm, input logic [7:0] op,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int a,
                         input int d, input logic [3:0] xbe,
                         input logic [31:0] xwd, input logic [31:0] xrd,
                         input logic xwe);
    bit st;
    st          = m_is_store(op);
    alu_op_i    = op;
    mem_addr_i  = addr;
    reg2_data_i = rs2;
    reg_waddr_i = 5'(addr[6:2] + 5'd1);
    reg_we_i    = 1'b1;
    reg_wdata_i = 32'h5A5A_0000 ^ addr;
    for (int c = 0; c <= a + d + 1; c++) begin
      data_addr_ok = (c == a);
      data_data_ok = (c == a + d);
      data_rdata   = (c == a + d) ? rdata : $urandom;
      @(negedge clk);
      chk({nm, ".stall"}, 32'(stall_from_mem), 32'(c <= a + d));
      chk({nm, ".req"}, 32'(data_req), 32'(c <= a));
      if (c <= a) begin
        chk({nm, ".addr"}, data_addr, addr & 32'hFFFF_FFFC);
        chk({nm, ".be"}, 32'(data_be), 32'(xbe));
        chk({nm, ".wr"}, 32'(data_wr), 32'(st));
        if (st) chk({nm, ".wdata"}, data_wdata, xwd);
      end
      if (c == a + d + 1) begin
        chk({nm, ".we"}, 32'(reg_we_o), 32'(xwe));
        chk({nm, ".waddr"}, 32'(reg_waddr_o), 32'(reg_waddr_i));
        if (!st) chk({nm, ".rd"}, reg_wdata_o, xrd);
      end
      @(posedge clk);
      #1;
    end
    idle_bus();
  endtask

  task automatic run_pass(input string nm, input logic [7:0] op,
                          input logic [31:0] v, input logic we);
    alu_op_i     = op;
    mem_addr_i   = $urandom;
    reg2_data_i  = $urandom;
    reg_waddr_i  = 5'(v[4:0]);
    reg_we_i     = we;
    reg_wdata_i  = v;
    data_data_ok = 1'b1;
    @(negedge clk);
    chk({nm, ".wd"}, reg_wdata_o, v);
    chk({nm, ".we"}, 32'(reg_we_o), 32'(we));
    chk({nm, ".waddr"}, 32'(reg_waddr_o), 32'(v[4:0]));
    chk({nm, ".stall"}, 32'(stall_from_mem), 32'd0);
    chk({nm, ".req"}, 32'(data_req), 32'd0);
    @(posedge clk);
    #1;
    idle_bus();
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          a;
    int          d;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        we;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] ops[11];

  initial begin
    rst          = 1'b1;
    alu_op_i     = EXE_LW_OP;
    mem_addr_i   = 32'h0000_0104;
    reg2_data_i  = 32'hFFFF_FFFF;
    reg_waddr_i  = 5'd7;
    reg_we_i     = 1'b1;
    reg_wdata_i  = 32'h1234_5678;
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = 32'hFFFF_FFFF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req", 32'(data_req), 32'd0);
    chk("rst.stall", 32'(stall_from_mem), 32'd0);
    chk("rst.we", 32'(reg_we_o), 32'd0);
    chk("rst.wd", reg_wdata_o, 32'd0);
    chk("rst.waddr", 32'(reg_waddr_o), 32'd0);
    chk("rst.be", 32'(data_be), 32'd0);
    chk("rst.addr", data_addr, 32'd0);
    @(posedge clk);
    #1;
    idle_bus();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.req", 32'(data_req), 32'd0);
    @(posedge clk);
    #1;

    tbl.push_back('{EXE_LW_OP, 32'h100, 32'h0, 32'h8899_AABB,
                    0, 0, 4'hF, 32'h0, 32'h8899_AABB, 1'b1});
    tbl.push_back('{EXE_LB_OP, 32'h103, 32'h0, 32'h8011_2233,
                    0, 0, 4'hF, 32'h0, 32'hFFFF_FF80, 1'b1});
    tbl.push_back('{EXE_LBU_OP, 32'h103, 32'h0, 32'h8011_2233,
                    0, 0, 4'hF, 32'h0, 32'h0000_0080, 1'b1});
    tbl.push_back('{EXE_SH_OP, 32'h102, 32'h1234_ABCD, 32'h0,
                    0, 0, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0});
    tbl.push_back('{EXE_LW_OP, 32'h200, 32'h0, 32'hCAFE_F00D,
                    3, 2, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b1});
    tbl.push_back('{EXE_LH_OP, 32'h102, 32'h0, 32'h8001_7FFF,
                    1, 0, 4'hF, 32'h0, 32'hFFFF_8001, 1'b1});
    tbl.push_back('{EXE_LHU_OP, 32'h100, 32'h0, 32'h8001_7FFF,
                    0, 1, 4'hF, 32'h0, 32'h0000_7FFF, 1'b1});
    tbl.push_back('{EXE_SB_OP, 32'h101, 32'h0000_00AB, 32'h0,
                    1, 1, 4'b0010, 32'hABAB_ABAB, 32'h0, 1'b0});
    tbl.push_back('{EXE_SW_OP, 32'h204, 32'h0123_4567, 32'h0,
                    0, 2, 4'hF, 32'h0123_4567, 32'h0, 1'b0});
    tbl.push_back('{EXE_LB_OP, 32'h100, 32'h0, 32'h0000_007F,
                    2, 0, 4'hF, 32'h0, 32'h0000_007F, 1'b1});
`ifndef MEM_ALIGN_CHECK_EN
    tbl.push_back('{EXE_LW_OP, 32'h102, 32'h0, 32'h1122_3344,
                    0, 0, 4'hF, 32'h0, 32'h1122_3344, 1'b1});
`endif

    foreach (tbl[i])
      run_acc($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr,
              tbl[i].rs2, tbl[i].rdata, tbl[i].a, tbl[i].d,
              tbl[i].be, tbl[i].wd, tbl[i].rd, tbl[i].we);

    run_pass("pass_add", EXE_ADD_OP, 32'hDEAD_BEEF, 1'b1);
    run_pass("pass_or", EXE_OR_OP, 32'h0000_0013, 1'b0);

    // reset while waiting for data_ok, then a late data_ok
    alu_op_i     = EXE_LW_OP;
    mem_addr_i   = 32'h300;
    reg_we_i     = 1'b1;
    data_addr_ok = 1'b1;
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("rw.req0", 32'(data_req), 32'd1);
    @(posedge clk);
    #1;
    data_addr_ok = 1'b0;
    @(negedge clk);
    chk("rw.wait_req", 32'(data_req), 32'd0);
    chk("rw.wait_stall", 32'(stall_from_mem), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rw.rst_stall", 32'(stall_from_mem), 32'd0);
    chk("rw.rst_we", 32'(reg_we_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_bus();
    data_data_ok = 1'b1;
    data_rdata   = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("rw.late_req", 32'(data_req), 32'd0);
    chk("rw.late_stall", 32'(stall_from_mem), 32'd0);
    chk("rw.late_we", 32'(reg_we_o), 32'd0);
    @(posedge clk);
    #1;
    idle_bus();
    @(negedge clk);
    chk("rw.idle_we", 32'(reg_we_o), 32'd0);
    @(posedge clk);
    #1;
    run_acc("rw.next", EXE_LW_OP, 32'h304, 32'h0, 32'h600D_F00D,
            0, 0, 4'hF, 32'h0, 32'h600D_F00D, 1'b1);

    ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_ADD_OP, EXE_OR_OP,
            EXE_AND_OP};
    for (int k = 0; k < 60; k++) begin
      logic [7:0]  op;
      logic [31:0] ad;
      logic [31:0] rs;
      logic [31:0] rd;
      op = ops[$urandom_range(0, 10)];
      ad = $urandom;
      rs = $urandom;
      rd = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      ad = ad & 32'hFFFF_FFFC;
`endif
      if (m_is_mem(op))
        run_acc($sformatf("rnd%0d", k), op, ad, rs, rd,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                m_be(op, ad), m_wdata(op, rs), m_load(op, ad, rd),
                !m_is_store(op));
      else
        run_pass($sformatf("rnd%0d", k), op, rd, 1'($urandom));
    end

`ifdef MEM_ALIGN_CHECK_EN
    alu_op_i     = EXE_LW_OP;
    mem_addr_i   = 32'h101;
    reg_we_i     = 1'b1;
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    @(negedge clk);
    chk("mis.req", 32'(data_req), 32'd0);
    chk("mis.err", 32'(addr_err_o), 32'd1);
    chk("mis.stall", 32'(stall_from_mem), 32'd0);
    chk("mis.we", 32'(reg_we_o), 32'd0);
    @(posedge clk);
    #1;
    alu_op_i = EXE_SH_OP;
    @(negedge clk);
    chk("mis.sh_err", 32'(addr_err_o), 32'd2);
    @(posedge clk);
    #1;
    idle_bus();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
